// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial adder controller around one full-adder cell
//
// Purpose:
//   Adds two WIDTH-bit unsigned operands one bit per clock, LSB first, using a
//   single full-adder cell built from two half_adder instances and an OR gate.
//   The controller owns the operand shift registers, the carry flop, the bit
//   counter and the start/busy/done handshake.
//
// Ports (serial_adder_ctrl):
//   i_clk    in   1      rising-edge clock
//   i_rst    in   1      synchronous, active-high reset
//   i_start  in   1      request, sampled only while idle
//   i_a      in   WIDTH  operand A, captured when start is accepted
//   i_b      in   WIDTH  operand B, captured when start is accepted
//   o_busy   out  1      high while adding and during the done cycle
//   o_done   out  1      one-cycle pulse, result valid in this cycle
//   o_sum    out  WIDTH  result register, held until the next result loads
//   o_cout   out  1      carry out of the MSB, held with o_sum
//
// Ports (half_adder):
//   i_a, i_b  in   1     addend bits
//   o_s       out  1     sum bit
//   o_c       out  1     carry bit

module half_adder (
  input  logic i_a,
  input  logic i_b,
  output logic o_s,
  output logic o_c
);

  assign o_s = i_a ^ i_b;
  assign o_c = i_a & i_b;

endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout
);

  // Counter only needs to reach WIDTH-1.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_res_sh;
  logic             r_c;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;

  logic             w_load;
  logic             w_step;
  logic             w_last;

  logic             w_s1;
  logic             w_c1;
  logic             w_s;
  logic             w_c2;
  logic             w_c_next;
  logic [WIDTH-1:0] w_res_next;

  // Full-adder cell: two half adders, carries merged with an OR.
  half_adder u_ha1 (
    .i_a (r_a_sh[0]),
    .i_b (r_b_sh[0]),
    .o_s (w_s1),
    .o_c (w_c1)
  );

  half_adder u_ha2 (
    .i_a (w_s1),
    .i_b (r_c),
    .o_s (w_s),
    .o_c (w_c2)
  );

  assign w_c_next = w_c1 | w_c2;

  // New sum bit enters at the MSB; after WIDTH shifts the first bit lands in bit 0.
  assign w_res_next = {w_s, r_res_sh[WIDTH-1:1]};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_step       = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_load       = 1'b1;
          w_state_next = S_ADD;
        end
      end
      S_ADD: begin
        w_step = 1'b1;
        if (r_cnt == LAST_BIT) begin
          w_last       = 1'b1;
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        // Start is not looked at here; a request must still be present in IDLE.
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_res_sh <= '0;
      r_c      <= 1'b0;
      r_cnt    <= '0;
      r_sum    <= '0;
      r_cout   <= 1'b0;
    end else begin
      if (w_load) begin
        r_a_sh   <= i_a;
        r_b_sh   <= i_b;
        r_res_sh <= '0;
        r_c      <= 1'b0;
        r_cnt    <= '0;
      end else if (w_step) begin
        r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
        r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
        r_res_sh <= w_res_next;
        r_c      <= w_c_next;
        r_cnt    <= r_cnt + CW'(1);
      end
      // Result registers update only when the last bit completes, so the
      // previous result stays visible for the whole next operation.
      if (w_last) begin
        r_sum  <= w_res_next;
        r_cout <= w_c_next;
      end
    end
  end

  assign o_busy = (r_state != S_IDLE);
  assign o_done = (r_state == S_DONE);
  assign o_sum  = r_sum;
  assign o_cout = r_cout;

endmodule
